// File: rtl/sp1_s_pkg.sv
// Shared constants and types for the SPI mode-0 slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sp1_s_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/sp1_edge_det.sv
// Rise/fall pulse generator for a clk-synchronous input, one history register.
// Latency: pulses are valid in the clk cycle where the new level is first seen.
// Backpressure: none; every edge produces exactly one single-cycle pulse.
module sp1_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig;
        end
    end

    assign rise = sig & ~prev_q;
    assign fall = ~sig & prev_q;

endmodule

// File: rtl/sp1_s.sv
// SPI mode-0 slave, MSB first: samples mosi on sp_clk rise, shifts miso on sp_clk fall.
// Latency: s_rece updates on the clk edge that sees the 8th sp_clk rise.
// Backpressure: none; the master owns the pace, ss high aborts any partial byte.
module sp1_s #(
    parameter int DATA_W = sp1_s_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_send,
    input  logic              sp_clk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic              busy_s,
    output logic [DATA_W-1:0] s_rece
);

    import sp1_s_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t            state_q;
    logic              ss_prev_q;
    logic [DATA_W-1:0] tx_q;
    // Only the first DATA_W-1 bits are stored; the final bit goes straight into s_rece.
    logic [DATA_W-2:0] rx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sp_rise;
    logic              sp_fall;

    sp1_edge_det u_sck_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sp_clk),
        .rise  (sp_rise),
        .fall  (sp_fall)
    );

    // ss_prev_q resets low so a frame only starts after ss has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ss_prev_q <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            s_rece    <= '0;
        end else begin
            ss_prev_q <= ss;
            case (state_q)
                IDLE: begin
                    if (!ss && ss_prev_q) begin
                        state_q <= XFER;
                        tx_q    <= data_send;
                        rx_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                XFER: begin
                    if (ss) begin
                        state_q <= IDLE;
                        tx_q    <= '0;
                        rx_q    <= '0;
                        cnt_q   <= '0;
                    end else if (sp_rise) begin
                        rx_q  <= {rx_q[DATA_W-3:0], mosi};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            s_rece <= {rx_q, mosi};
                        end
                    end else if (sp_fall) begin
                        // Counter back at zero means a byte just completed: start the next one.
                        if (cnt_q == '0) begin
                            tx_q <= data_send;
                        end else begin
                            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso   = tx_q[DATA_W-1];
    assign busy_s = (state_q == XFER);

endmodule

// File: tb/tb_sp1_s.sv
module tb_sp1_s;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_send;
    logic       sp_clk;
    logic       mosi;
    logic       ss;
    logic       miso;
    logic       busy_s;
    logic [7:0] s_rece;

    int checks = 0;
    int errors = 0;

    sp1_s #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_send (data_send),
        .sp_clk    (sp_clk),
        .mosi      (mosi),
        .ss        (ss),
        .miso      (miso),
        .busy_s    (busy_s),
        .s_rece    (s_rece)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mo;
        logic [7:0] send;
        logic [7:0] exp_rece;
        logic [7:0] exp_miso;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] d);
        data_send = d;
        ss = 1'b0;
        tick(2);
    endtask

    task automatic end_frame();
        ss = 1'b1;
        tick(2);
    endtask

    // Master side: nbits bits of mo MSB first; miso captured as the master would at each rise.
    task automatic xfer_byte(input logic [7:0] mo, input logic [7:0] next_send,
                             input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(1);
            mi[7-i] = miso;
            sp_clk = 1'b1;
            tick(2);
            check("busy_in_frame", busy_s, 1'b1);
            if (i == 7) data_send = next_send;
            sp_clk = 1'b0;
            tick(2);
        end
    endtask

    vec_t       vecs[5];
    logic [7:0] mi;
    logic [7:0] last_rece;
    logic [7:0] exp_send;
    logic [7:0] mo_r;
    logic [7:0] nxt_r;

    initial begin
        vecs[0] = '{mo: 8'hAB, send: 8'hAB, exp_rece: 8'hAB, exp_miso: 8'hAB};
        vecs[1] = '{mo: 8'h8E, send: 8'h8E, exp_rece: 8'h8E, exp_miso: 8'h8E};
        vecs[2] = '{mo: 8'h3C, send: 8'hC3, exp_rece: 8'h3C, exp_miso: 8'hC3};
        vecs[3] = '{mo: 8'h00, send: 8'hFF, exp_rece: 8'h00, exp_miso: 8'hFF};
        vecs[4] = '{mo: 8'hFF, send: 8'h01, exp_rece: 8'hFF, exp_miso: 8'h01};

        rst_n = 1'b0; ss = 1'b1; sp_clk = 1'b0; mosi = 1'b0; data_send = 8'h00;
        #1;
        check("reset_s_rece", s_rece, 8'h00);
        check("reset_busy", busy_s, 1'b0);
        check("reset_miso", miso, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", busy_s, 1'b0);

        // Table-driven single-byte frames
        foreach (vecs[k]) begin
            start_frame(vecs[k].send);
            check("tbl_miso_first", miso, {31'd0, vecs[k].send[7]});
            xfer_byte(vecs[k].mo, 8'h00, 8, mi);
            check("tbl_s_rece", s_rece, vecs[k].exp_rece);
            check("tbl_miso_byte", mi, vecs[k].exp_miso);
            end_frame();
            check("tbl_busy_after", busy_s, 1'b0);
            check("tbl_miso_idle", miso, 1'b0);
        end
        last_rece = 8'hFF;

        // Idle activity on sp_clk/mosi is ignored
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            sp_clk = ~sp_clk;
            tick(1);
            check("idle_miso", miso, 1'b0);
        end
        sp_clk = 1'b0;
        tick(1);
        check("idle_s_rece", s_rece, last_rece);
        check("idle_busy2", busy_s, 1'b0);

        // Back-to-back bytes, data_send changed before the 8th fall
        start_frame(8'hAB);
        xfer_byte(8'h12, 8'h61, 8, mi);
        check("b2b_rece1", s_rece, 8'h12);
        check("b2b_miso1", mi, 8'hAB);
        xfer_byte(8'h34, 8'h00, 8, mi);
        check("b2b_rece2", s_rece, 8'h34);
        check("b2b_miso2", mi, 8'h61);
        end_frame();
        last_rece = 8'h34;

        // Abort after 5 bits, then a clean 0x8E frame
        start_frame(8'h5A);
        xfer_byte(8'hF0, 8'h00, 5, mi);
        end_frame();
        check("abort_rece", s_rece, last_rece);
        check("abort_busy", busy_s, 1'b0);
        check("abort_miso", miso, 1'b0);
        start_frame(8'h8E);
        xfer_byte(8'h8E, 8'h00, 8, mi);
        check("abort_next_rece", s_rece, 8'h8E);
        check("abort_next_miso", mi, 8'h8E);
        end_frame();
        last_rece = 8'h8E;

        // ss rises on the same edge as the 8th sp_clk rise: bit must be dropped
        start_frame(8'h00);
        xfer_byte(8'h77, 8'h00, 7, mi);
        mosi = 1'b1;
        tick(1);
        sp_clk = 1'b1;
        ss = 1'b1;
        tick(2);
        check("ss_prio_rece", s_rece, last_rece);
        check("ss_prio_busy", busy_s, 1'b0);
        sp_clk = 1'b0;
        tick(2);

        // Reset mid-frame, ss left low through release
        start_frame(8'hC5);
        xfer_byte(8'hA0, 8'h00, 3, mi);
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", miso, 1'b0);
        check("rst_mid_busy", busy_s, 1'b0);
        check("rst_mid_rece", s_rece, 8'h00);
        sp_clk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("rst_wait_ss", busy_s, 1'b0);
        ss = 1'b1;
        tick(2);
        start_frame(8'h3C);
        xfer_byte(8'h3C, 8'h00, 8, mi);
        check("rst_next_rece", s_rece, 8'h3C);
        check("rst_next_miso", mi, 8'h3C);
        end_frame();
        last_rece = 8'h3C;

        // Randomised frames against a byte-level model
        for (int f = 0; f < 30; f++) begin
            int nb;
            int part;
            nb = int'($urandom_range(1, 3));
            part = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
            exp_send = 8'($urandom);
            start_frame(exp_send);
            for (int b = 0; b < nb; b++) begin
                mo_r = 8'($urandom);
                nxt_r = 8'($urandom);
                xfer_byte(mo_r, nxt_r, 8, mi);
                last_rece = mo_r;
                check("rnd_rece", s_rece, last_rece);
                check("rnd_miso", mi, exp_send);
                exp_send = nxt_r;
            end
            if (part != 0) begin
                mo_r = 8'($urandom);
                xfer_byte(mo_r, 8'($urandom), part, mi);
                check("rnd_part_miso", 32'(mi >> (8 - part)), 32'(exp_send >> (8 - part)));
            end
            end_frame();
            check("rnd_end_rece", s_rece, last_rece);
            check("rnd_end_busy", busy_s, 1'b0);
            check("rnd_end_miso", miso, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
